// File: rtl/cmp_arbiter.sv
// Two-port round-robin front end for a shared less/equal comparator.
// Operands are registered on grant, compared in a dedicated cycle, and the tagged result is held until accepted.
module cmp_arbiter #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WORDSIZE-1:0] req0_a,
    input  logic [WORDSIZE-1:0] req0_b,
    input  logic                req0_signed,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WORDSIZE-1:0] req1_a,
    input  logic [WORDSIZE-1:0] req1_b,
    input  logic                req1_signed,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic                resp_less,
    output logic                resp_equal,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                last_grant;
    logic                grant;
    logic                handshake;
    logic [WORDSIZE-1:0] a_q;
    logic [WORDSIZE-1:0] b_q;
    logic                signed_q;
    logic                id_q;
    logic                less_c;
    logic                equal_c;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) &&  grant && req1_valid;
    assign handshake  = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        less_c  = 1'b0;
        equal_c = (a_q == b_q);
        if (signed_q) begin
            less_c = ($signed(a_q) < $signed(b_q));
        end else begin
            less_c = (a_q < b_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = CMP;
            CMP:     state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            id_q       <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_less  <= 1'b0;
            resp_equal <= 1'b0;
        end else begin
            if (handshake) begin
                a_q        <= grant ? req1_a : req0_a;
                b_q        <= grant ? req1_b : req0_b;
                signed_q   <= grant ? req1_signed : req0_signed;
                id_q       <= grant;
                last_grant <= grant;
            end
            if (state == CMP) begin
                resp_less  <= less_c;
                resp_equal <= equal_c;
                resp_id    <= id_q;
                resp_valid <= 1'b1;
            end
            if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one 64-bit less/equal comparator between two requesters, e.g. the branch unit (port 0) and the SLT/SLTU path (port 1).
- Grants requests round-robin, registers the operands, evaluates the flags in a dedicated cycle, and holds a tagged result until the consumer accepts it.
- Sits between the decode/execute stage and the flag logic of the processor datapath.

Parameters:
- WORDSIZE, 64, operand width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a comparison pending.
- req0_ready  output  1  requester 0 is granted this cycle.
- req0_a  input  WORDSIZE  requester 0 operand A.
- req0_b  input  WORDSIZE  requester 0 operand B.
- req0_signed  input  1  1 = signed compare, 0 = unsigned.
- req1_valid  input  1  requester 1 has a comparison pending.
- req1_ready  output  1  requester 1 is granted this cycle.
- req1_a  input  WORDSIZE  requester 1 operand A.
- req1_b  input  WORDSIZE  requester 1 operand B.
- req1_signed  input  1  1 = signed compare, 0 = unsigned.
- resp_valid  output  1  result is available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  1  index of the requester that owns the result.
- resp_less  output  1  A < B under the captured signedness.
- resp_equal  output  1  A == B.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, CMP, RESP, held in a registered state variable.
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - resp_valid=0, resp_id=0, resp_less=0, resp_equal=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Operand registers cleared to 0.
  - Any in-flight operation is discarded; no response is issued for it.
- Grant (combinational, meaningful only in IDLE):
  - If only one reqN_valid is high, grant N.
  - If both are high, grant the index != last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid.
  - Both ready outputs are 0 outside IDLE.
  - At most one ready is ever high.
- IDLE → CMP on a handshake (reqN_valid && reqN_ready): capture a, b, signed and id=N; set last_grant<=N.
- CMP → RESP unconditionally after one cycle:
  - less is computed from the registered operands: signed compare if the captured signed bit is 1, otherwise unsigned.
  - equal is a bitwise equality of all WORDSIZE bits.
  - Write resp_less, resp_equal and resp_id; set resp_valid<=1.
- RESP: resp_valid, resp_id, resp_less and resp_equal stay stable until resp_valid && resp_ready. On acceptance, resp_valid<=0 and state → IDLE.
- Latency and throughput:
  - Grant edge to resp_valid high is 2 cycles.
  - Minimum spacing between grants is 3 cycles when resp_ready is held at 1.
- Valid rules:
  - Requesters may drop valid before being granted; nothing is captured in that case.
  - Inputs are ignored outside IDLE.
  - Changes to operand inputs after the grant edge do not affect the result.
- Simultaneous events:
  - A request arriving in the same cycle as RESP acceptance is not granted that cycle. It is granted in the following IDLE cycle.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1,…
- resp_ready high while resp_valid is low has no effect.

Test Plan:
- Reset, then req0: a=5, b=2, signed=1 → req0_ready at the grant edge; 2 cycles later resp_valid=1, resp_id=0, less=0, equal=0.
- req1: a=5, b=5, unsigned → resp_id=1, less=0, equal=1. Hold resp_ready=0 for 4 cycles → outputs stable and busy=1 throughout.
- Signedness on the same operands, a=64'hFFFF_FFFF_FFFF_FFFF, b=1:
  - signed=1 → less=1.
  - signed=0 → less=0.
  - a=1, b=64'h1000_0000_0000_0001 → less=1 in both modes.
- Both valid continuously with a=1, b=5 → first grant to 0, then alternation 0,1,0,1; each result has less=1 with the matching resp_id; never both ready in one cycle.
- Assert rst_n=0 during CMP and again during RESP → all outputs 0 immediately; no response is ever produced for the aborted operation; the next request completes normally.
- req0_valid pulsed for one cycle while the block is in RESP, then dropped → no grant and no capture; the block returns to IDLE and stays idle.
